// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit between the execute stage and a data memory
//             with a valid/ready request channel and a separate read-response
//             strobe. One operation is in flight at a time. Loads return an
//             aligned, sign/zero-extended result. Stores drive byte strobes
//             and lane-replicated write data.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1   clock, all state changes on the rising edge
//    rst_n       in   1   synchronous active-low reset
//    req_valid   in   1   execute stage presents a memory op
//    req_ready   out  1   LSU idle, op accepted on req_valid && req_ready
//    req_we      in   1   1 = store, 0 = load
//    req_funct3  in   3   access size / signedness
//    req_addr    in  32   effective address
//    req_wdata   in  32   store data
//    mem_valid   out  1   memory request valid
//    mem_ready   in   1   memory request accepted
//    mem_addr    out 32   word address
//    mem_we      out  1   memory write enable
//    mem_wstrb   out  4   byte strobes
//    mem_wdata   out 32   lane-replicated store data
//    mem_rvalid  in   1   load response valid
//    mem_rdata   in  32   load response data
//    wb_valid    out  1   one-cycle completion pulse
//    wb_data     out 32   load result (0 for stores and rejected ops)
//    busy        out  1   operation in progress
//    misalign    out  1   misaligned-access pulse (LSU_MISALIGN_TRAP_EN only)
// ----------------------------------------------------------------------------
//  Build option
//    LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses are
//                           rejected and flagged on misalign. When undefined,
//                           the address bits below natural alignment are
//                           masked off instead.
// ============================================================================
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        busy
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_supported;
    logic        w_misaligned;
    logic        w_skip;
    logic [1:0]  w_size;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    // ------------------------------------------------------------------
    // Request decode (combinational from the execute-stage inputs)
    // ------------------------------------------------------------------
    assign w_size = req_funct3[1:0];

    always_comb begin
        w_supported = 1'b0;
        if (req_we) begin
            w_supported = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                          (req_funct3 == 3'b010);
        end else begin
            w_supported = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                          (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                          (req_funct3 == 3'b101);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = w_supported &&
                          (((w_size == c_SIZE_HALF) && req_addr[0]) ||
                           ((w_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    // Rejected ops bypass the memory and complete straight away.
    assign w_skip = !w_supported || w_misaligned;

    // Low address bits forced to natural alignment; only matters when
    // misaligned ops are not trapped.
    always_comb begin
        w_addr_lo = req_addr[1:0];
        if (w_size == c_SIZE_HALF) begin
            w_addr_lo = {req_addr[1], 1'b0};
        end else if (w_size == c_SIZE_WORD) begin
            w_addr_lo = 2'b00;
        end
    end

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = req_wdata;
        case (w_size)
            c_SIZE_BYTE: begin
                w_wstrb = 4'b0001 << w_addr_lo;
                w_wdata = {4{req_wdata[7:0]}};
            end
            c_SIZE_HALF: begin
                w_wstrb = 4'b0011 << w_addr_lo;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
        if (!req_we) begin
            w_wstrb = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Load data extraction from the returned word
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_byte = mem_rdata[7:0];
        case (r_addr_lo)
            2'd0:    w_ld_byte = mem_rdata[7:0];
            2'd1:    w_ld_byte = mem_rdata[15:8];
            2'd2:    w_ld_byte = mem_rdata[23:16];
            default: w_ld_byte = mem_rdata[31:24];
        endcase
        w_ld_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_ld_data = 32'd0;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            3'b010:  w_ld_data = mem_rdata;
            default: w_ld_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req_ready    = 1'b0;
        mem_valid    = 1'b0;
        wb_valid     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_skip ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    w_state_next = r_we ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                wb_valid     = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_mem_addr  <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_wb_data   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we      <= req_we;
                r_funct3  <= req_funct3;
                r_addr_lo <= w_addr_lo;
                if (w_skip) begin
                    r_wb_data <= 32'd0;
                end else begin
                    // Bus fields only move for ops that will really issue.
                    r_mem_addr  <= {req_addr[31:2], 2'b00};
                    r_mem_we    <= req_we;
                    r_mem_wstrb <= w_wstrb;
                    r_mem_wdata <= w_wdata;
                end
            end
            if ((r_state == S_REQ) && mem_ready && r_we) begin
                r_wb_data <= 32'd0;
            end
            if ((r_state == S_RESP) && mem_rvalid) begin
                r_wb_data <= w_ld_data;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_misalign <= w_misaligned;
        end
    end

    assign misalign = r_misalign && (r_state == S_DONE);
`endif

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;
    assign wb_data   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Scoreboard bench for lsu. Directed operations push their
//             expected memory transaction and write-back result into queues;
//             a memory responder and a write-back monitor pop and compare.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        busy;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    // Memory-side inputs are driven either by the responder or by a
    // hand-driven sequence; each source owns its own variables.
    logic        rsp_ready = 1'b0, rsp_rvalid = 1'b0;
    logic [31:0] rsp_rdata = 32'd0;
    logic        man_ready = 1'b0, man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    logic        rsp_en = 1'b1;

    assign mem_ready  = rsp_ready | man_ready;
    assign mem_rvalid = rsp_rvalid | man_rvalid;
    assign mem_rdata  = rsp_rdata | man_rdata;

    lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .busy       (busy)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign   (misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdly;
        int          vdly;
    } mem_item_t;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } wb_item_t;

    mem_item_t mem_q[$];
    wb_item_t  wb_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Memory responder: pops the expected transaction when a request shows
    // up, checks the bus fields and their stability, then responds.
    // ------------------------------------------------------------------
    initial begin
        mem_item_t it;
        forever begin
            @(negedge clk);
            if (rsp_en && mem_valid) begin
                if (mem_q.size() == 0) begin
                    fail_now("unexpected memory access");
                    rsp_ready = 1'b1;
                    @(posedge clk);
                    #1 rsp_ready = 1'b0;
                    if (!mem_we) begin
                        @(negedge clk);
                        rsp_rvalid = 1'b1;
                        @(posedge clk);
                        #1 rsp_rvalid = 1'b0;
                    end
                end else begin
                    it = mem_q.pop_front();
                    chk("mem_addr", mem_addr, it.addr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, it.we});
                    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, it.wstrb});
                    if (it.we) chk("mem_wdata", mem_wdata, it.wdata);
                    repeat (it.rdly) begin
                        @(negedge clk);
                        chk("stall mem_valid", {31'd0, mem_valid}, 32'd1);
                        chk("stall mem_addr", mem_addr, it.addr);
                        chk("stall busy", {31'd0, busy}, 32'd1);
                    end
                    rsp_ready = 1'b1;
                    @(posedge clk);
                    #1 rsp_ready = 1'b0;
                    if (!it.we) begin
                        repeat (it.vdly) begin
                            @(negedge clk);
                            chk("resp-wait mem_valid", {31'd0, mem_valid}, 32'd0);
                            chk("resp-wait busy", {31'd0, busy}, 32'd1);
                        end
                        @(negedge clk);
                        rsp_rvalid = 1'b1;
                        rsp_rdata  = it.rdata;
                        @(posedge clk);
                        #1;
                        rsp_rvalid = 1'b0;
                        rsp_rdata  = 32'd0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-back monitor
    // ------------------------------------------------------------------
    initial begin
        wb_item_t w;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    fail_now("unexpected wb_valid");
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_data", wb_data, w.data);
`ifdef LSU_MISALIGN_TRAP_EN
                    chk("misalign", {31'd0, misalign}, {31'd0, w.mis});
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_mem(input logic [31:0] addr, input logic we, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int rdly, input int vdly);
        mem_item_t it;
        it.addr = addr; it.we = we; it.wstrb = wstrb; it.wdata = wdata;
        it.rdata = rdata; it.rdly = rdly; it.vdly = vdly;
        mem_q.push_back(it);
    endtask

    task automatic push_wb(input logic [31:0] data, input logic mis);
        wb_item_t w;
        w.data = data; w.mis = mis;
        wb_q.push_back(w);
    endtask

    // Issues one op, waits for its completion pulse, checks latency when
    // exp_lat > 0 (edges counted from the accepting edge).
    task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
        int  n;
        int  g;
        bit  done;
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) fail_now({name, " req_ready timeout"});
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (wb_valid) done = 1'b1;
        end
        if (!done) fail_now({name, " wb_valid timeout"});
        else if (exp_lat > 0) chk({name, " latency"}, n, exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("reset mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("reset misalign", {31'd0, misalign}, 32'd0);
`endif

        // LW, zero-wait memory
        push_mem(32'h100, 1'b0, 4'b0000, 32'd0, 32'hDEADBEEF, 0, 0);
        push_wb(32'hDEADBEEF, 1'b0);
        do_op("LW 0x100", 1'b0, 3'b010, 32'h100, 32'd0, 3);
        repeat (3) @(negedge clk);
        chk("wb_data hold", wb_data, 32'hDEADBEEF);
        chk("idle busy", {31'd0, busy}, 32'd0);

        // Byte / half extraction
        push_mem(32'h100, 1'b0, 4'b0000, 32'd0, 32'h80112233, 0, 0);
        push_wb(32'hFFFFFF80, 1'b0);
        do_op("LB 0x103", 1'b0, 3'b000, 32'h103, 32'd0, 3);
        push_mem(32'h100, 1'b0, 4'b0000, 32'd0, 32'h80112233, 0, 0);
        push_wb(32'h00000080, 1'b0);
        do_op("LBU 0x103", 1'b0, 3'b100, 32'h103, 32'd0, 3);
        push_mem(32'h100, 1'b0, 4'b0000, 32'd0, 32'h80112233, 0, 0);
        push_wb(32'h00008011, 1'b0);
        do_op("LHU 0x102", 1'b0, 3'b101, 32'h102, 32'd0, 3);
        push_mem(32'h100, 1'b0, 4'b0000, 32'd0, 32'h80112233, 0, 0);
        push_wb(32'hFFFF8011, 1'b0);
        do_op("LH 0x102", 1'b0, 3'b001, 32'h102, 32'd0, 3);
        push_mem(32'h100, 1'b0, 4'b0000, 32'd0, 32'h80112233, 0, 0);
        push_wb(32'h00000033, 1'b0);
        do_op("LB 0x100", 1'b0, 3'b000, 32'h100, 32'd0, 3);
        push_mem(32'h104, 1'b0, 4'b0000, 32'd0, 32'h7F00A5C3, 0, 0);
        push_wb(32'h0000007F, 1'b0);
        do_op("LB 0x107", 1'b0, 3'b000, 32'h107, 32'd0, 3);

        // Stores
        push_mem(32'h204, 1'b1, 4'b1100, 32'hABCDABCD, 32'd0, 0, 0);
        push_wb(32'd0, 1'b0);
        do_op("SH 0x206", 1'b1, 3'b001, 32'h206, 32'h0000ABCD, 2);
        push_mem(32'h300, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'd0, 0, 0);
        push_wb(32'd0, 1'b0);
        do_op("SB 0x301", 1'b1, 3'b000, 32'h301, 32'h123456A5, 2);
        push_mem(32'h400, 1'b1, 4'b1111, 32'hCAFEF00D, 32'd0, 0, 0);
        push_wb(32'd0, 1'b0);
        do_op("SW 0x400", 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 2);

        // LW with a slow memory
        push_mem(32'h500, 1'b0, 4'b0000, 32'd0, 32'h0BADF00D, 3, 2);
        push_wb(32'h0BADF00D, 1'b0);
        do_op("LW slow", 1'b0, 3'b010, 32'h500, 32'd0, 0);

        // Unsupported encodings: no memory access, immediate completion
        push_wb(32'd0, 1'b0);
        do_op("load f3=011", 1'b0, 3'b011, 32'h600, 32'd0, 1);
        push_wb(32'd0, 1'b0);
        do_op("store f3=011", 1'b1, 3'b011, 32'h600, 32'h11111111, 1);
        push_wb(32'd0, 1'b0);
        do_op("store f3=100", 1'b1, 3'b100, 32'h600, 32'h11111111, 1);

        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        push_wb(32'd0, 1'b1);
        do_op("LW 0x101", 1'b0, 3'b010, 32'h101, 32'd0, 1);
        push_wb(32'd0, 1'b1);
        do_op("LH 0x103", 1'b0, 3'b001, 32'h103, 32'd0, 1);
        push_wb(32'd0, 1'b1);
        do_op("SW 0x402", 1'b1, 3'b010, 32'h402, 32'h12345678, 1);
`else
        push_mem(32'h100, 1'b0, 4'b0000, 32'd0, 32'h11223344, 0, 0);
        push_wb(32'h11223344, 1'b0);
        do_op("LW 0x101", 1'b0, 3'b010, 32'h101, 32'd0, 3);
        push_mem(32'h100, 1'b0, 4'b0000, 32'd0, 32'h80112233, 0, 0);
        push_wb(32'hFFFF8011, 1'b0);
        do_op("LH 0x103", 1'b0, 3'b001, 32'h103, 32'd0, 3);
        push_mem(32'h400, 1'b1, 4'b1111, 32'h12345678, 32'd0, 0, 0);
        push_wb(32'd0, 1'b0);
        do_op("SW 0x402", 1'b1, 3'b010, 32'h402, 32'h12345678, 2);
`endif

        // Reset while waiting for a load response, then a stray response
        rsp_en = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h700;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst-test mem_valid", {31'd0, mem_valid}, 32'd1);
        man_ready = 1'b1;
        @(posedge clk);
        #1 man_ready = 1'b0;
        @(negedge clk);
        chk("rst-test busy in RESP", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("post-reset busy", {31'd0, busy}, 32'd0);
        chk("post-reset mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("post-reset wb_data", wb_data, 32'd0);
        man_rvalid = 1'b1;
        man_rdata  = 32'h12345678;
        @(posedge clk);
        #1;
        man_rvalid = 1'b0;
        man_rdata  = 32'd0;
        repeat (3) begin
            @(negedge clk);
            chk("stray rvalid wb_valid", {31'd0, wb_valid}, 32'd0);
            chk("stray rvalid busy", {31'd0, busy}, 32'd0);
        end
        chk("stray rvalid wb_data", wb_data, 32'd0);
        rsp_en = 1'b1;

        // Normal operation resumes after the aborted transaction
        push_mem(32'h800, 1'b0, 4'b0000, 32'd0, 32'h00FF00FF, 0, 0);
        push_wb(32'h00FF00FF, 1'b0);
        do_op("LW after reset", 1'b0, 3'b010, 32'h800, 32'd0, 3);

        g = 0;
        while ((mem_q.size() != 0 || wb_q.size() != 0) && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("mem queue drained", mem_q.size(), 32'd0);
        chk("wb queue drained", wb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
